awb_gain: RTL
=============

AWB_GAIN -- requirements
Module: awb_gain

Interface
REQ-001 The block SHALL have parameter source_h, default 512: active pixels per line.
REQ-002 The block SHALL have parameter source_v, default 512: active lines per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port awb_en, input, 1 bit: 1 applies computed gains; 0 forces unity gains.
REQ-006 The block SHALL have ports in_vsync, in_hsync and in_den, inputs, 1 bit each: timing from the demosaic stage; vsync is high during the frame.
REQ-007 The block SHALL have ports in_data_R, in_data_G and in_data_B, inputs, 8 bits each: demosaiced pixel.
REQ-008 The block SHALL have ports out_vsync, out_hsync and out_den, outputs, 1 bit each: timing delayed to match the data.
REQ-009 The block SHALL have ports out_data_R, out_data_G and out_data_B, outputs, 8 bits each: white-balanced pixel.
REQ-010 The block SHALL have ports gain_R and gain_B, outputs, 12 bits each: active gains, unsigned Q4.8 format.

Function
REQ-011 The block SHALL accumulate sum_R, sum_G and sum_B, 28 bits each, over every cycle where in_den=1 and in_vsync=1.
REQ-012 The block SHALL clear the sums on the rising edge of in_vsync.
REQ-013 The block SHALL treat the falling edge of in_vsync as frame end and latch the three sums into snapshot registers on that edge.
REQ-014 The FSM SHALL have states IDLE, DIV_R, DIV_B and DONE, and SHALL take these transitions:
- IDLE -> DIV_R on frame end;
- DIV_R -> DIV_B when the divider reports done;
- DIV_B -> DONE when the divider reports done;
- DONE -> IDLE after 1 cycle.
REQ-015 In DIV_R the block SHALL compute pend_R = (snap_G << 8) / snap_R; in DIV_B it SHALL compute pend_B = (snap_G << 8) / snap_B.
REQ-016 The divider SHALL be a shared sequential restoring divider with a 36-bit dividend, producing 1 quotient bit per cycle, and finishing in at most 40 cycles.
REQ-017 A divisor of 0 SHALL yield a pending gain of 0x100.
REQ-018 A quotient greater than 0xFFF SHALL clamp to 0xFFF.
REQ-019 In DONE the block SHALL set a pending-valid flag.
REQ-020 On the next rising edge of in_vsync with pending-valid set, the block SHALL copy pend_R and pend_B into gain_R and gain_B and clear the flag; gains SHALL never change mid-frame.
REQ-021 If frame end occurs while the FSM is not IDLE, the block SHALL ignore that frame end; the in-progress computation SHALL continue.
REQ-022 If a rising edge of in_vsync occurs before DONE, the block SHALL keep the old gains; the pending result SHALL apply at the following frame start.
REQ-023 The effective gain SHALL be 0x100 for G always, and 0x100 for R and B when awb_en=0; awb_en SHALL be sampled combinationally in pipeline stage 1.
REQ-024 The datapath SHALL be a 2-stage pipeline:
- stage 1 registers the 8x12 products (20 bits);
- stage 2 computes (product >> 8) and saturates to 255.
REQ-025 The block SHALL delay out_vsync, out_hsync and out_den by exactly 2 cycles so they stay aligned with the data.
REQ-026 The block SHALL compute outputs independently of in_den; it SHALL NOT force blanking data.

Reset
REQ-027 Asserting reset SHALL immediately set all outputs to 0, gain_R and gain_B to 0x100, the sums and snapshots to 0, the FSM to IDLE, the pending-valid flag to 0 and the divider to idle.
REQ-028 Reset asserted mid-division SHALL abort the division; no partial result SHALL be applied.

Structure
REQ-029 A shared ISP header SHALL define GAIN_W=12, GAIN_FRAC=8, GAIN_UNITY=12'h100, SUM_W=28 and the FSM state encodings.
REQ-030 The divider SHALL be a sub-module named awb_div with start, dividend, divisor, done and quotient ports; all other logic SHALL reside in awb_gain.

Verification
REQ-031 A bench SHALL cover a uniform frame with R=G=B=100 -> gains remain 0x100, and next-frame output equals input with 2-cycle latency.
REQ-032 A bench SHALL cover a frame with R=50, G=100, B=200 -> at the next frame start gain_R=0x200 and gain_B=0x080, and next-frame pixel (50,100,200) outputs (100,100,100).
REQ-033 A bench SHALL cover a frame with R=10, G=200, B=200 -> gain_R clamps to 0xFFF, and next-frame pixel (10,200,200) outputs R=159.
REQ-034 A bench SHALL cover a frame with R=0 everywhere -> gain_R=0x100, with no hang; the FSM returns to IDLE within 90 cycles of frame end.
REQ-035 A bench SHALL cover awb_en=0 with gains 0x200/0x080 loaded -> output equals input.
REQ-036 A bench SHALL cover reset pulsed 10 cycles into DIV_R -> FSM IDLE, gains 0x100, and the following frame passes through unchanged.

Source files
------------

// File: rtl/awb_gain_pkg.sv
// Shared ISP definitions for the white-balance block: gain format, sum widths, FSM states.
// Also holds the gain clamp and pixel scale/saturate helpers used by the datapath.
package awb_gain_pkg;

    localparam int GAIN_W    = 12;
    localparam int GAIN_FRAC = 8;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 12'h100;
    localparam logic [GAIN_W-1:0] GAIN_MAX   = 12'hFFF;
    localparam int SUM_W     = 28;
    localparam int PIX_W     = 8;
    localparam int DIVD_W    = SUM_W + GAIN_FRAC;
    localparam int PROD_W    = PIX_W + GAIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_R = 2'd1,
        DIV_B = 2'd2,
        DONE  = 2'd3
    } awb_state_t;

    // A channel with no energy has no meaningful ratio, so it keeps unity gain.
    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [DIVD_W-1:0] quo,
                                                     input logic              div_zero);
        if (div_zero) begin
            return GAIN_UNITY;
        end
        if (|quo[DIVD_W-1:GAIN_W]) begin
            return GAIN_MAX;
        end
        return quo[GAIN_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] scale_pix(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] sh;
        sh = prod >> GAIN_FRAC;
        if (|sh[PROD_W-1:PIX_W]) begin
            return {PIX_W{1'b1}};
        end
        return sh[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/awb_div.sv
// Restoring divider, one quotient bit per cycle; done pulses 37 cycles after start.
// No backpressure: a start while busy restarts the division with the new operands.
module awb_div
    import awb_gain_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIVD_W-1:0] dividend,
    input  logic [SUM_W-1:0]  divisor,
    output logic              done,
    output logic [DIVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVD_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVD_W - 1);

    logic [DIVD_W-1:0] quo_q, quo_d;
    logic [SUM_W-1:0]  rem_q, rem_d, dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q, done_q;
    logic [SUM_W:0]    shifted, trial;

    always_comb begin
        shifted = {rem_q, quo_q[DIVD_W-1]};
        trial   = shifted - {1'b0, dvs_q};
        quo_d   = {quo_q[DIVD_W-2:0], 1'b0};
        rem_d   = shifted[SUM_W-1:0];
        // No borrow means the divisor fits into the partial remainder.
        if (!trial[SUM_W]) begin
            quo_d[0] = 1'b1;
            rem_d    = trial[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                quo_q  <= dividend;
                rem_q  <= '0;
                dvs_q  <= divisor;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                quo_q <= quo_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/awb_gain.sv
// Auto white balance: measures G/R and G/B per frame and applies the gains from the next frame on.
// Pixel path latency 2 cycles; no backpressure, a pixel is accepted every cycle.
module awb_gain
    import awb_gain_pkg::*;
#(
    parameter int source_h = 512,
    parameter int source_v = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              awb_en,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [PIX_W-1:0]  in_data_R,
    input  logic [PIX_W-1:0]  in_data_G,
    input  logic [PIX_W-1:0]  in_data_B,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [PIX_W-1:0]  out_data_R,
    output logic [PIX_W-1:0]  out_data_G,
    output logic [PIX_W-1:0]  out_data_B,
    output logic [GAIN_W-1:0] gain_R,
    output logic [GAIN_W-1:0] gain_B
);

    localparam longint FRAME_MAX    = longint'(source_h) * longint'(source_v) * 255;
    localparam bit     SUM_CAN_WRAP = FRAME_MAX >= (longint'(1) << SUM_W);

    // Oversized frames pin the sum at full scale instead of wrapping to a tiny value.
    function automatic logic [SUM_W-1:0] acc(input logic [SUM_W-1:0] sum,
                                             input logic [PIX_W-1:0] pix);
        logic [SUM_W:0] s;
        s = {1'b0, sum} + {{(SUM_W-PIX_W+1){1'b0}}, pix};
        if (SUM_CAN_WRAP && s[SUM_W]) begin
            return {SUM_W{1'b1}};
        end
        return s[SUM_W-1:0];
    endfunction

    logic              vs_q, rise, fall;
    logic [SUM_W-1:0]  sum_r_q, sum_g_q, sum_b_q;
    logic [SUM_W-1:0]  sum_r_d, sum_g_d, sum_b_d;
    logic [SUM_W-1:0]  snap_r_q, snap_g_q, snap_b_q;
    awb_state_t        state_q, state_d;
    logic              start_q, start_d;
    logic              div_done;
    logic [DIVD_W-1:0] div_quo;
    logic [SUM_W-1:0]  div_divisor;
    logic [GAIN_W-1:0] pend_r_q, pend_b_q, gain_r_q, gain_b_q;
    logic              pend_vld_q;
    logic [GAIN_W-1:0] geff_r, geff_b;
    logic [PROD_W-1:0] prod_r_q, prod_g_q, prod_b_q;
    logic [PIX_W-1:0]  pix_r_q, pix_g_q, pix_b_q;
    logic [2:0]        tim1_q, tim2_q;

    assign rise = in_vsync & ~vs_q;
    assign fall = ~in_vsync & vs_q;

    always_comb begin
        sum_r_d = rise ? '0 : sum_r_q;
        sum_g_d = rise ? '0 : sum_g_q;
        sum_b_d = rise ? '0 : sum_b_q;
        if (in_vsync && in_den) begin
            sum_r_d = acc(sum_r_d, in_data_R);
            sum_g_d = acc(sum_g_d, in_data_G);
            sum_b_d = acc(sum_b_d, in_data_B);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q     <= 1'b0;
            sum_r_q  <= '0;
            sum_g_q  <= '0;
            sum_b_q  <= '0;
            snap_r_q <= '0;
            snap_g_q <= '0;
            snap_b_q <= '0;
        end else begin
            vs_q    <= in_vsync;
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
            // Snapshots stay frozen while a computation is using them.
            if (fall && state_q == IDLE) begin
                snap_r_q <= sum_r_q;
                snap_g_q <= sum_g_q;
                snap_b_q <= sum_b_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = DIV_R;
                    start_d = 1'b1;
                end
            end
            DIV_R: begin
                if (div_done) begin
                    state_d = DIV_B;
                    start_d = 1'b1;
                end
            end
            DIV_B: begin
                if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // start is registered so the divider loads operands after the snapshot has landed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    assign div_divisor = (state_q == DIV_B) ? snap_b_q : snap_r_q;

    awb_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (start_q),
        .dividend ({snap_g_q, {GAIN_FRAC{1'b0}}}),
        .divisor  (div_divisor),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r_q   <= GAIN_UNITY;
            pend_b_q   <= GAIN_UNITY;
            pend_vld_q <= 1'b0;
            gain_r_q   <= GAIN_UNITY;
            gain_b_q   <= GAIN_UNITY;
        end else begin
            if (state_q == DIV_R && div_done) begin
                pend_r_q <= clamp_gain(div_quo, snap_r_q == '0);
            end
            if (state_q == DIV_B && div_done) begin
                pend_b_q <= clamp_gain(div_quo, snap_b_q == '0);
            end
            if (rise && pend_vld_q) begin
                gain_r_q   <= pend_r_q;
                gain_b_q   <= pend_b_q;
                pend_vld_q <= 1'b0;
            end
            // A result finishing on a frame-start cycle waits for the next frame start.
            if (state_q == DONE) begin
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign geff_r = awb_en ? gain_r_q : GAIN_UNITY;
    assign geff_b = awb_en ? gain_b_q : GAIN_UNITY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            pix_r_q  <= '0;
            pix_g_q  <= '0;
            pix_b_q  <= '0;
            tim1_q   <= '0;
            tim2_q   <= '0;
        end else begin
            prod_r_q <= PROD_W'(in_data_R) * PROD_W'(geff_r);
            prod_g_q <= PROD_W'(in_data_G) * PROD_W'(GAIN_UNITY);
            prod_b_q <= PROD_W'(in_data_B) * PROD_W'(geff_b);
            pix_r_q  <= scale_pix(prod_r_q);
            pix_g_q  <= scale_pix(prod_g_q);
            pix_b_q  <= scale_pix(prod_b_q);
            tim1_q   <= {in_vsync, in_hsync, in_den};
            tim2_q   <= tim1_q;
        end
    end

    assign {out_vsync, out_hsync, out_den} = tim2_q;
    assign out_data_R = pix_r_q;
    assign out_data_G = pix_g_q;
    assign out_data_B = pix_b_q;
    assign gain_R     = gain_r_q;
    assign gain_B     = gain_b_q;

endmodule
